// File: rtl/shift_rotate_sequencer_if.sv
// Control-sequencer side of the shift/rotate unit: request fields in, status and result back.
// start is the request strobe; the unit takes it on any edge where busy is low, and done pulses once per finished operation.
`timescale 1ns/1ps
interface shift_rotate_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, operand, amount,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand, amount,
        output busy, done, result
    );
endinterface

// File: rtl/shift_rotate_sequencer.sv
// Bit-serial shift/rotate unit: one step per clock, result held for Z capture after done.
`timescale 1ns/1ps
module shift_rotate_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic                   clk,
    input  logic                   clr,
    shift_rotate_sequencer_if.slave bus,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b111;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic [AMT_W-1:0] count;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             is_pass;
    logic [AMT_W-1:0] first_n;
    logic [WIDTH-1:0] step;
    logic             unused_amount_hi;

    assign accept           = bus.start && (state == IDLE || state == DONE);
    assign is_pass          = bus.op[2] && (bus.op[1] || bus.op[0]);
    // PASS runs no steps, so the count is forced to zero at acceptance.
    assign first_n          = is_pass ? '0 : bus.amount[AMT_W-1:0];
    assign unused_amount_hi = ^bus.amount[WIDTH-1:AMT_W];

    always_comb begin
        step = result_q;
        case (op_q)
            OP_SHR:  step = {1'b0, result_q[WIDTH-1:1]};
            OP_SHRA: step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            OP_SHL:  step = {result_q[WIDTH-2:0], 1'b0};
            OP_ROR:  step = {result_q[0], result_q[WIDTH-1:1]};
            OP_ROL:  step = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            default: step = result_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            op_q     <= OP_PASS;
            result_q <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (accept) begin
            op_q     <= bus.op;
            result_q <= bus.operand;
            count    <= first_n;
            if (first_n == '0) begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                state  <= RUN;
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    result_q <= step;
                    count    <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign dbg_state  = state;
endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Directed bench for shift_rotate_sequencer: latency, busy length, results, ignore/restart and reset abort.
`timescale 1ns/1ps
module tb_shift_rotate_sequencer;
    logic        clk;
    logic        clr;
    logic [1:0]  dbg_state;
    int          checks;
    int          failures;
    logic [31:0] exp_q[$];

    shift_rotate_sequencer_if #(.WIDTH(32)) bus ();

    shift_rotate_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1ns after a rising edge; that next edge is E0. Returns 1ns after the done edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] a,
                          output int cyc, output int bcyc, output logic [31:0] res, output bit to);
        bus.op = o; bus.operand = d; bus.amount = a; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.operand = $urandom; bus.amount = $urandom;
        cyc = 0; bcyc = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) bcyc++;
            @(posedge clk); #1;
            cyc++;
        end
        to  = !bus.done;
        res = bus.result;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 3'b000; bus.operand = '0; bus.amount = '0;
        clr = 1'b0;
        #23;
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 00000000", bus.result); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_shifts();
        logic [2:0]  ops[7]  = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b100, 3'b010, 3'b000};
        logic [31:0] dins[7] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h12345678,
                                 32'h80000001, 32'h00000001, 32'h00000100};
        logic [31:0] amts[7] = '{32'd4, 32'd31, 32'd2, 32'd8, 32'd1, 32'd31, 32'd33};
        int          ns[7]   = '{4, 31, 2, 8, 1, 31, 1};
        logic [31:0] exps[7] = '{32'h08000000, 32'hFFFFFFFF, 32'h10000000, 32'h78123456,
                                 32'h00000003, 32'h80000000, 32'h00000080};
        int cyc, bcyc; logic [31:0] res; bit to;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], dins[i], amts[i], cyc, bcyc, res, to);
            checks++; if (to) begin failures++; $display("FAIL shift%0d_timeout: no done within %0d cycles", i, cyc); end
            checks++; if (cyc != ns[i]) begin failures++; $display("FAIL shift%0d_latency: got %0d want %0d", i, cyc, ns[i]); end
            checks++; if (bcyc != ns[i]) begin failures++; $display("FAIL shift%0d_busy: got %0d want %0d", i, bcyc, ns[i]); end
            checks++; if (res !== exps[i]) begin failures++; $display("FAIL shift%0d_result: got %h want %h", i, res, exps[i]); end
            @(posedge clk); #1;
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL shift%0d_done_pulse: got %b want 0", i, bus.done); end
            checks++; if (bus.result !== exps[i]) begin failures++; $display("FAIL shift%0d_hold: got %h want %h", i, bus.result, exps[i]); end
            checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL shift%0d_idle: got %0d want 0", i, dbg_state); end
        end
    endtask

    // Back-to-back zero-length ops: each done lands in the very next cycle.
    task automatic test_zero_amount();
        logic [2:0]  ops[3]  = '{3'b000, 3'b010, 3'b111};
        logic [31:0] dins[3] = '{32'h0000ABCD, 32'h00001234, 32'h5555AAAA};
        logic [31:0] amts[3] = '{32'd0, 32'd32, 32'd5};
        int cyc, bcyc; logic [31:0] res; bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], dins[i], amts[i], cyc, bcyc, res, to);
            checks++; if (cyc != 0 || to) begin failures++; $display("FAIL zero%0d_latency: got %0d want 0", i, cyc); end
            checks++; if (bcyc != 0) begin failures++; $display("FAIL zero%0d_busy: got %0d want 0", i, bcyc); end
            checks++; if (res !== dins[i]) begin failures++; $display("FAIL zero%0d_result: got %h want %h", i, res, dins[i]); end
        end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL zero_done_drop: got %b want 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc; bit to; logic [31:0] res;
        exp_q.push_back(32'h9E048D15);
        exp_q.push_back(32'h0000000F);
        bus.op = 3'b011; bus.operand = 32'h12345678; bus.amount = 32'd10; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b010; bus.operand = 32'hFFFFFFFF; bus.amount = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 2; bcyc = 0;
        while (!bus.done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = exp_q.pop_front();
        checks++; if (cyc != 10) begin failures++; $display("FAIL ignore_latency: got %0d want 10", cyc); end
        checks++; if (bus.result !== res) begin failures++; $display("FAIL ignore_result: got %h want %h", bus.result, res); end
        // Second request raised in the DONE cycle.
        run_op(3'b000, 32'h000000F0, 32'd4, cyc, bcyc, res, to);
        checks++; if (to || cyc != 4) begin failures++; $display("FAIL restart_latency: got %0d want 4", cyc); end
        checks++; if (bcyc != 4) begin failures++; $display("FAIL restart_busy: got %0d want 4", bcyc); end
        checks++; if (res !== exp_q[0]) begin failures++; $display("FAIL restart_result: got %h want %h", res, exp_q[0]); end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic test_clr_abort();
        int cyc, bcyc; bit to; logic [31:0] res; int seen;
        bus.op = 3'b010; bus.operand = 32'h1; bus.amount = 32'd20; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL abort_result: got %h want 00000000", bus.result); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
            if (k == 2) clr = 1'b1;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_done: got %0d done cycles want 0", seen); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL abort_idle: got %0d want 0", dbg_state); end
        run_op(3'b010, 32'h1, 32'd3, cyc, bcyc, res, to);
        checks++; if (to || cyc != 3) begin failures++; $display("FAIL post_clr_latency: got %0d want 3", cyc); end
        checks++; if (res !== 32'h00000008) begin failures++; $display("FAIL post_clr_result: got %h want 00000008", res); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_shifts();
        test_zero_amount();
        test_back_to_back();
        test_clr_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
